recorder_ctrl: RTL and testbench

- Top-level transport controller for the audio recorder; consumes the three debounced (clean) front-panel button levels: record, play, stop.
- Sequences sample memory addressing for record and playback at the audio sample rate; tracks recording length.
- Handles pause and long-press-stop erase.
- Sits between the debounce instances and the sample RAM / codec datapath.

---
 rtl/recorder_pkg.sv | 11 +
 rtl/btn_edge.sv | 17 +
 rtl/recorder_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_recorder_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/recorder_pkg.sv
// Shared transport encodings for the recorder controller, datapath and display logic.
package recorder_pkg;

   localparam int unsigned ADDR_BITS = 18;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] RECORD = 2'd1;
   localparam logic [1:0] PLAY   = 2'd2;
   localparam logic [1:0] PAUSE  = 2'd3;

endpackage

// File: rtl/btn_edge.sv
// Registered rising-edge detector for one debounced button level.
module btn_edge (
   input  logic clk,
   input  logic btn_i,
   output logic rise_o
);

   logic prev_q;

   // Reset also loads the live level, so a button held through reset yields no edge.
   always_ff @(posedge clk) begin
      prev_q <= btn_i;
   end

   assign rise_o = btn_i & ~prev_q;

endmodule

// File: rtl/recorder_ctrl.sv
// Transport controller: record/play/pause sequencing of sample RAM addresses and
// long-press-stop erase of the stored recording.
module recorder_ctrl #(
   parameter int unsigned          ADDR_BITS   = recorder_pkg::ADDR_BITS,
   parameter logic [ADDR_BITS-1:0] MAX_ADDR    = {ADDR_BITS{1'b1}},
   parameter int unsigned          LONG_CYCLES = 93750000,
   parameter int unsigned          LONG_BITS   = 27
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 btn_rec,
   input  logic                 btn_play,
   input  logic                 btn_stop,
   input  logic                 sample_tick,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic                 mem_we,
   output logic                 play_strobe,
   output logic [ADDR_BITS:0]   rec_len,
   output logic [1:0]           state,
   output logic                 erase_done
);

   import recorder_pkg::*;

   localparam logic [LONG_BITS-1:0] HoldLast = LONG_BITS'(LONG_CYCLES - 1);

   logic rise_rec, rise_play, rise_stop;

   btn_edge u_edge_rec (
      .clk    (clk),
      .btn_i  (btn_rec),
      .rise_o (rise_rec)
   );

   btn_edge u_edge_play (
      .clk    (clk),
      .btn_i  (btn_play),
      .rise_o (rise_play)
   );

   btn_edge u_edge_stop (
      .clk    (clk),
      .btn_i  (btn_stop),
      .rise_o (rise_stop)
   );

   logic [1:0]           state_q, state_d;
   logic [ADDR_BITS-1:0] addr_q, addr_d;
   logic [ADDR_BITS:0]   len_q, len_d;
   logic [LONG_BITS-1:0] hold_q, hold_d;
   logic                 we_q, we_d;
   logic                 strobe_q, strobe_d;
   logic                 erase_q, erase_d;

   logic [ADDR_BITS:0]   addr_inc;
   logic                 len_nz;
   logic                 play_last;

   assign addr_inc  = {1'b0, addr_q} + (ADDR_BITS + 1)'(1);
   assign len_nz    = (len_q != '0);
   assign play_last = (addr_inc == len_q);

   // A write/strobe cycle keeps the address stable; the address advances on the
   // following edge, which is also where rec_len picks up the completed write.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      len_d    = len_q;
      hold_d   = '0;
      we_d     = 1'b0;
      strobe_d = 1'b0;
      erase_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (btn_stop) begin
               if (len_nz && hold_q == HoldLast) begin
                  erase_d = 1'b1;
                  len_d   = '0;
                  hold_d  = hold_q;
               end else if (len_nz) begin
                  hold_d = hold_q + LONG_BITS'(1);
               end else begin
                  hold_d = hold_q;
               end
            end
            if (!rise_stop) begin
               if (rise_rec) begin
                  state_d = RECORD;
                  addr_d  = '0;
                  len_d   = '0;
               end else if (rise_play && len_nz && !erase_d) begin
                  state_d = PLAY;
                  addr_d  = '0;
               end
            end
         end

         RECORD: begin
            if (we_q) begin
               len_d = addr_inc;
            end
            if (rise_stop) begin
               state_d = IDLE;
               addr_d  = '0;
            end else if (we_q) begin
               if (addr_q == MAX_ADDR) begin
                  state_d = IDLE;
                  addr_d  = '0;
               end else begin
                  addr_d = addr_inc[ADDR_BITS-1:0];
               end
            end else if (sample_tick) begin
               we_d = 1'b1;
            end
         end

         PLAY: begin
            if (rise_stop) begin
               state_d = IDLE;
               addr_d  = '0;
            end else if (strobe_q && play_last) begin
               state_d = IDLE;
               addr_d  = '0;
            end else if (rise_play) begin
               state_d = PAUSE;
               if (strobe_q) begin
                  addr_d = addr_inc[ADDR_BITS-1:0];
               end
            end else if (strobe_q) begin
               addr_d = addr_inc[ADDR_BITS-1:0];
            end else if (sample_tick) begin
               strobe_d = 1'b1;
            end
         end

         PAUSE: begin
            if (rise_stop) begin
               state_d = IDLE;
               addr_d  = '0;
            end else if (rise_play) begin
               state_d = PLAY;
            end
         end

         default: begin
            state_d = IDLE;
            addr_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         len_q    <= '0;
         hold_q   <= '0;
         we_q     <= 1'b0;
         strobe_q <= 1'b0;
         erase_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         len_q    <= len_d;
         hold_q   <= hold_d;
         we_q     <= we_d;
         strobe_q <= strobe_d;
         erase_q  <= erase_d;
      end
   end

   assign mem_addr    = addr_q;
   assign mem_we      = we_q;
   assign play_strobe = strobe_q;
   assign rec_len     = len_q;
   assign state       = state_q;
   assign erase_done  = erase_q;

endmodule

// File: tb/tb_recorder_ctrl.sv
// Bench for recorder_ctrl: directed transport scenarios plus random button/tick traffic
// checked against a transaction-level model of the recorder.
module tb_recorder_ctrl;

   import recorder_pkg::*;

   localparam int unsigned AB    = 3;
   localparam int          DEPTH = 8;
   localparam int unsigned LONG  = 10;

   logic          clk = 1'b0;
   logic          reset;
   logic          btn_rec, btn_play, btn_stop, sample_tick;
   logic [AB-1:0] mem_addr;
   logic          mem_we, play_strobe, erase_done;
   logic [AB:0]   rec_len;
   logic [1:0]    state;

   int n_assert = 0;
   int n_fail   = 0;
   int act_wr[$], act_rd[$], exp_wr[$], exp_rd[$];
   int erase_cnt = 0;
   int m_mode, m_pos, m_len;

   always #5 clk = ~clk;

   recorder_ctrl #(
      .ADDR_BITS   (AB),
      .LONG_CYCLES (LONG),
      .LONG_BITS   (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .btn_rec     (btn_rec),
      .btn_play    (btn_play),
      .btn_stop    (btn_stop),
      .sample_tick (sample_tick),
      .mem_addr    (mem_addr),
      .mem_we      (mem_we),
      .play_strobe (play_strobe),
      .rec_len     (rec_len),
      .state       (state),
      .erase_done  (erase_done)
   );

   always @(negedge clk) begin
      if (!reset) begin
         if (mem_we) act_wr.push_back(int'(mem_addr));
         if (play_strobe) act_rd.push_back(int'(mem_addr));
         if (erase_done) erase_cnt++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Transaction-level model: a sample either lands at the next position or ends the take.
   task automatic m_tick();
      if (m_mode == 1) begin
         exp_wr.push_back(m_pos);
         m_pos++;
         m_len = m_pos;
         if (m_pos == DEPTH) begin m_mode = 0; m_pos = 0; end
      end else if (m_mode == 2) begin
         exp_rd.push_back(m_pos);
         m_pos++;
         if (m_pos == m_len) begin m_mode = 0; m_pos = 0; end
      end
   endtask

   task automatic m_button(input int b);
      if (b == 2) begin
         if (m_mode != 0) begin m_mode = 0; m_pos = 0; end
      end else if (b == 0) begin
         if (m_mode == 0) begin m_mode = 1; m_pos = 0; m_len = 0; end
      end else begin
         if (m_mode == 0 && m_len != 0) begin m_mode = 2; m_pos = 0; end
         else if (m_mode == 2) m_mode = 3;
         else if (m_mode == 3) m_mode = 2;
      end
   endtask

   task automatic set_btn(input int b, input logic v);
      if (b == 0) btn_rec = v;
      else if (b == 1) btn_play = v;
      else btn_stop = v;
   endtask

   task automatic do_tick();
      sample_tick = 1'b1;
      cyc(1);
      sample_tick = 1'b0;
      cyc(4);
      m_tick();
   endtask

   task automatic do_press(input int b);
      set_btn(b, 1'b1);
      cyc(2);
      set_btn(b, 1'b0);
      cyc(2);
      m_button(b);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc(2);
      reset = 1'b0;
      cyc(1);
      m_mode = 0; m_pos = 0; m_len = 0;
      act_wr.delete(); act_rd.delete(); exp_wr.delete(); exp_rd.delete();
   endtask

   task automatic check_model(input string tag);
      check({tag, ".state"}, 32'(state), 32'(m_mode));
      check({tag, ".addr"}, 32'(mem_addr), 32'(m_pos));
      check({tag, ".len"}, 32'(rec_len), 32'(m_len));
   endtask

   task automatic check_queues(input string tag);
      check({tag, ".wr_n"}, 32'(act_wr.size()), 32'(exp_wr.size()));
      for (int i = 0; i < exp_wr.size() && i < act_wr.size(); i++)
         check({tag, ".wr_addr"}, 32'(act_wr[i]), 32'(exp_wr[i]));
      check({tag, ".rd_n"}, 32'(act_rd.size()), 32'(exp_rd.size()));
      for (int i = 0; i < exp_rd.size() && i < act_rd.size(); i++)
         check({tag, ".rd_addr"}, 32'(act_rd[i]), 32'(exp_rd[i]));
      act_wr.delete(); act_rd.delete(); exp_wr.delete(); exp_rd.delete();
   endtask

   initial begin
      int erase_at;
      int cnt0;
      int r;

      reset = 1'b1;
      btn_rec = 1'b1; btn_play = 1'b0; btn_stop = 1'b0; sample_tick = 1'b0;
      m_mode = 0; m_pos = 0; m_len = 0;
      cyc(3);
      check("rst.we", 32'(mem_we), 0);
      check("rst.strobe", 32'(play_strobe), 0);
      check("rst.erase", 32'(erase_done), 0);
      reset = 1'b0;
      cyc(2);
      check_model("held_rec");
      btn_rec = 1'b0;
      cyc(2);
      check_model("held_rec_release");

      do_press(0);
      check_model("rec_start");
      for (int i = 0; i < 5; i++) do_tick();
      check("rec5.len_before_stop", 32'(rec_len), 5);
      do_press(2);
      check_model("rec5_stop");
      check_queues("rec5");

      do_press(1);
      do_tick(); do_tick();
      do_press(1);
      check("pause.state", 32'(state), 32'(PAUSE));
      for (int i = 0; i < 3; i++) do_tick();
      check_model("pause_hold");
      do_press(1);
      for (int i = 0; i < 3; i++) do_tick();
      check_model("play_done");
      check_queues("play");

      do_press(0);
      for (int i = 0; i < 8; i++) do_tick();
      check_model("full_8");
      do_tick();
      check_model("full_9");
      check_queues("full");

      do_press(0);
      for (int i = 0; i < 3; i++) do_tick();
      btn_stop = 1'b1; sample_tick = 1'b1;
      cyc(1);
      sample_tick = 1'b0;
      cyc(1);
      btn_stop = 1'b0;
      cyc(3);
      m_button(2);
      check_model("stop_tick");
      check_queues("stop_tick");

      do_press(0);
      for (int i = 0; i < 5; i++) do_tick();
      do_press(2);
      check_queues("pre_erase");
      erase_at = -1;
      cnt0 = erase_cnt;
      btn_stop = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         cyc(1);
         if (erase_done && erase_at < 0) erase_at = i;
      end
      btn_stop = 1'b0;
      cyc(2);
      m_len = 0;
      check("erase.cycle", 32'(erase_at), 32'(LONG));
      check("erase.pulses", 32'(erase_cnt - cnt0), 1);
      check_model("erase");
      do_press(1);
      check_model("play_after_erase");

      do_reset();
      check_model("rnd_reset");
      for (int n = 0; n < 200; n++) begin
         r = int'($urandom_range(0, 12));
         if (r <= 6) do_tick();
         else if (r <= 8) do_press(0);
         else if (r <= 10) do_press(1);
         else if (r == 11) do_press(2);
         else begin
            check_queues("rnd_pre_reset");
            do_reset();
         end
         check_model("rnd");
      end
      check_queues("rnd_end");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
